// File: rtl/syscall_unit_pkg.sv
// Shared constants for the syscall service unit: service codes, FSM encoding
// and console payload kinds.
package syscall_unit_pkg;

  localparam logic [31:0] SVC_PRINT_INT  = 32'd1;
  localparam logic [31:0] SVC_PRINT_STR  = 32'd4;
  localparam logic [31:0] SVC_EXIT       = 32'd10;
  localparam logic [31:0] SVC_PRINT_CHAR = 32'd11;

  localparam logic KIND_CHAR = 1'b0;
  localparam logic KIND_INT  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_EMIT     = 3'd1,
    ST_STR_REQ  = 3'd2,
    ST_STR_WAIT = 3'd3,
    ST_STR_EMIT = 3'd4,
    ST_DONE     = 3'd5,
    ST_HALTED   = 3'd6
  } state_e;

  function automatic logic [31:0] char_word(input logic [7:0] c);
    return {24'b0, c};
  endfunction

endpackage

// File: rtl/syscall_unit_byte_lane_sel.sv
// Little-endian byte lane extractor: lane 0 is bits 7:0.
module byte_lane_sel (
  input  logic [31:0] word_i,
  input  logic [1:0]  sel_i,
  output logic [7:0]  byte_o
);

  always_comb begin
    byte_o = word_i[7:0];
    case (sel_i)
      2'd0: byte_o = word_i[7:0];
      2'd1: byte_o = word_i[15:8];
      2'd2: byte_o = word_i[23:16];
      2'd3: byte_o = word_i[31:24];
      default: byte_o = word_i[7:0];
    endcase
  end

endmodule

// File: rtl/syscall_unit.sv
// MIPS syscall service unit: stalls the core while emitting console output,
// walking a NUL-terminated string from data memory, or halting.
module syscall_unit #(
  parameter int unsigned MAX_STR = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        syscall,
  input  logic [31:0] v0,
  input  logic [31:0] a0,
  output logic        stall,
  output logic        halt,
  output logic        err,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_kind,
  output logic [31:0] out_data
);
  import syscall_unit_pkg::*;

  localparam int unsigned CNT_W = $clog2(MAX_STR + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_STR);

  state_e           state_q, state_d;
  logic [31:0]      ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic [31:0]      data_q, data_d;
  logic             kind_q, kind_d;
  logic             err_q, err_d;
  logic [7:0]       lane_byte;

  byte_lane_sel u_lane (
    .word_i (mem_rdata),
    .sel_i  (ptr_q[1:0]),
    .byte_o (lane_byte)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      kind_q  <= KIND_CHAR;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      kind_q  <= kind_d;
      err_q   <= err_d;
    end
  end

  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    kind_d  = kind_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (syscall) begin
          ptr_d = a0;
          case (v0)
            SVC_PRINT_INT: begin
              data_d  = a0;
              kind_d  = KIND_INT;
              state_d = ST_EMIT;
            end
            SVC_PRINT_CHAR: begin
              data_d  = char_word(a0[7:0]);
              kind_d  = KIND_CHAR;
              state_d = ST_EMIT;
            end
            SVC_PRINT_STR: begin
              cnt_d   = '0;
              state_d = ST_STR_REQ;
            end
            SVC_EXIT: state_d = ST_HALTED;
            default: begin
              err_d   = 1'b1;
              state_d = ST_DONE;
            end
          endcase
        end
      end
      ST_EMIT: begin
        if (out_ready) state_d = ST_DONE;
      end
      ST_STR_REQ: state_d = ST_STR_WAIT;
      ST_STR_WAIT: begin
        if (lane_byte == 8'h00) begin
          state_d = ST_DONE;
        end else begin
          data_d  = char_word(lane_byte);
          kind_d  = KIND_CHAR;
          state_d = ST_STR_EMIT;
        end
      end
      ST_STR_EMIT: begin
        if (out_ready) begin
          ptr_d = ptr_q + 32'd1;
          cnt_d = cnt_inc;
          // Hitting the character budget ends the service without a NUL fetch.
          if (cnt_inc == CNT_MAX) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_STR_REQ;
          end
        end
      end
      // DONE never re-samples syscall: it is still the retiring instruction.
      ST_DONE:   state_d = ST_IDLE;
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign stall     = ((state_q == ST_IDLE) && syscall) ||
                     ((state_q != ST_IDLE) && (state_q != ST_DONE));
  assign halt      = (state_q == ST_HALTED);
  assign err       = err_q;
  assign out_valid = (state_q == ST_EMIT) || (state_q == ST_STR_EMIT);
  assign out_kind  = kind_q;
  assign out_data  = data_q;
  assign mem_addr  = {ptr_q[31:2], 2'b00};

endmodule

// File: tb/tb_syscall_unit.sv
// Directed bench for syscall_unit: vector table of services plus hand-written
// halt, back-to-back and reset-mid-service sequences.
module tb_syscall_unit;

  localparam logic [31:0] BASE = 32'h1001_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        syscall;
  logic [31:0] v0, a0;
  logic        stall, halt, err;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        out_valid, out_ready, out_kind;
  logic [31:0] out_data;

  int passed = 0;
  int total  = 0;

  logic [7:0]  mem_b [0:63];
  logic [31:0] addr_log [0:15];

  syscall_unit #(.MAX_STR(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .syscall   (syscall),
    .v0        (v0),
    .a0        (a0),
    .stall     (stall),
    .halt      (halt),
    .err       (err),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_kind  (out_kind),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] addr);
    logic [31:0] w;
    logic [31:0] off;
    w = '0;
    for (int i = 0; i < 4; i++) begin
      off = addr + i - BASE;
      if (off < 32'd64) w[8*i +: 8] = mem_b[off[5:0]];
    end
    return w;
  endfunction

  always @(posedge clk) mem_rdata <= word_at(mem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  // Starts at a negedge; returns at the negedge after DONE with syscall low.
  task automatic run_op(input logic [31:0] v, input logic [31:0] a, input int rl,
                        output int stalls, output int xfers, output int errs,
                        output logic [31:0] d0, output logic [31:0] dl, output logic k,
                        output int unstable, output int errvalid, output logic timeout);
    int vcnt, cyc;
    logic done, prev_hold, prev_k;
    logic [31:0] prev_d;
    stalls = 0; xfers = 0; errs = 0; d0 = '0; dl = '0; k = 1'b0;
    unstable = 0; errvalid = 0; vcnt = 0; cyc = 0; done = 1'b0;
    prev_hold = 1'b0; prev_d = '0; prev_k = 1'b0;
    syscall = 1'b1; v0 = v; a0 = a; out_ready = 1'b0;
    while (!done && cyc < 100) begin
      if (cyc > 0) @(negedge clk);
      #1;
      if (out_valid) begin
        out_ready = (vcnt >= rl);
        vcnt++;
      end else begin
        out_ready = 1'b0;
      end
      #1;
      if (cyc < 16) addr_log[cyc] = mem_addr;
      if (err) errs++;
      if (err && out_valid) errvalid++;
      if (prev_hold && (out_data !== prev_d || out_kind !== prev_k)) unstable++;
      if (out_valid && out_ready) begin
        if (xfers == 0) d0 = out_data;
        dl = out_data;
        k  = out_kind;
        xfers++;
      end
      prev_hold = out_valid && !out_ready;
      prev_d = out_data;
      prev_k = out_kind;
      if (!stall) done = 1'b1;
      else stalls++;
      cyc++;
    end
    timeout = !done;
    @(negedge clk);
    syscall = 1'b0;
    out_ready = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic [31:0] v0;
    logic [31:0] a0;
    int          ready_low;
    int          exp_stalls;
    int          exp_xfers;
    logic [31:0] exp_d0;
    logic [31:0] exp_dl;
    logic        exp_kind;
    int          exp_err;
  } vec_t;

  vec_t vecs [0:10];

  int st, xf, er, unst, ev, vcount;
  logic [31:0] d0, dl;
  logic kd, to;

  initial begin
    for (int i = 0; i < 64; i++) mem_b[i] = 8'h00;
    mem_b[2]  = 8'h48; mem_b[3]  = 8'h69; mem_b[4]  = 8'h00;
    mem_b[8]  = 8'h00;
    mem_b[16] = 8'h41; mem_b[17] = 8'h42; mem_b[18] = 8'h43;
    mem_b[19] = 8'h44; mem_b[20] = 8'h45; mem_b[21] = 8'h46; mem_b[22] = 8'h47;
    mem_b[32] = 8'h55;
    mem_b[33] = 8'h78; mem_b[34] = 8'h79; mem_b[35] = 8'h7A; mem_b[36] = 8'h00;

    vecs[0]  = '{"char_A",      32'd11, 32'h0000_0041, 0, 2,  1, 32'h41,        32'h41,        1'b0, 0};
    vecs[1]  = '{"int_bp3",     32'd1,  32'hFFFF_FFFF, 3, 5,  1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0};
    vecs[2]  = '{"char_lowbyte",32'd11, 32'h1234_5678, 0, 2,  1, 32'h78,        32'h78,        1'b0, 0};
    vecs[3]  = '{"int_zero",    32'd1,  32'h0000_0000, 0, 2,  1, 32'h0,         32'h0,         1'b1, 0};
    vecs[4]  = '{"unknown7",    32'd7,  32'h0000_0000, 0, 1,  0, 32'h0,         32'h0,         1'b0, 1};
    vecs[5]  = '{"unknown0",    32'd0,  32'hDEAD_BEEF, 0, 1,  0, 32'h0,         32'h0,         1'b0, 1};
    vecs[6]  = '{"str_Hi",      32'd4,  32'h1001_0002, 0, 9,  2, 32'h48,        32'h69,        1'b0, 0};
    vecs[7]  = '{"str_empty",   32'd4,  32'h1001_0008, 0, 3,  0, 32'h0,         32'h0,         1'b0, 0};
    vecs[8]  = '{"str_trunc",   32'd4,  32'h1001_0010, 0, 13, 4, 32'h41,        32'h44,        1'b0, 1};
    vecs[9]  = '{"str_xyz",     32'd4,  32'h1001_0021, 0, 12, 3, 32'h78,        32'h7A,        1'b0, 0};
    vecs[10] = '{"char_bp1",    32'd11, 32'h0000_007E, 1, 3,  1, 32'h7E,        32'h7E,        1'b0, 0};

    rst_n = 1'b0; syscall = 1'b0; v0 = '0; a0 = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_stall", {31'b0, stall}, 32'd0);
    check("rst_halt", {31'b0, halt}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_kind", {31'b0, out_kind}, 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].v0, vecs[i].a0, vecs[i].ready_low, st, xf, er, d0, dl, kd, unst, ev, to);
      check({vecs[i].name, "_timeout"}, {31'b0, to}, 32'd0);
      check({vecs[i].name, "_stalls"}, st, vecs[i].exp_stalls);
      check({vecs[i].name, "_xfers"}, xf, vecs[i].exp_xfers);
      check({vecs[i].name, "_err"}, er, vecs[i].exp_err);
      check({vecs[i].name, "_stable"}, unst, 32'd0);
      check({vecs[i].name, "_err_valid"}, ev, 32'd0);
      if (vecs[i].exp_xfers > 0) begin
        check({vecs[i].name, "_first"}, d0, vecs[i].exp_d0);
        check({vecs[i].name, "_last"}, dl, vecs[i].exp_dl);
        check({vecs[i].name, "_kind"}, {31'b0, kd}, {31'b0, vecs[i].exp_kind});
      end
      if (i == 6) begin
        check("Hi_addr0", addr_log[1], 32'h1001_0000);
        check("Hi_addr1", addr_log[4], 32'h1001_0000);
        check("Hi_addr2", addr_log[7], 32'h1001_0004);
      end
      #1;
      check({vecs[i].name, "_idle_stall"}, {31'b0, stall}, 32'd0);
      check({vecs[i].name, "_idle_err"}, {31'b0, err}, 32'd0);
      @(negedge clk);
    end

    // Back-to-back: syscall stays high across DONE into the next instruction.
    run_op(32'd11, 32'h61, 0, st, xf, er, d0, dl, kd, unst, ev, to);
    syscall = 1'b1; v0 = 32'd11; a0 = 32'h62;
    run_op(32'd11, 32'h62, 0, st, xf, er, d0, dl, kd, unst, ev, to);
    check("b2b_timeout", {31'b0, to}, 32'd0);
    check("b2b_second", d0, 32'h62);
    check("b2b_xfers", xf, 32'd1);
    @(negedge clk);

    // Reset in the middle of a string while a character is offered.
    syscall = 1'b1; v0 = 32'd4; a0 = 32'h1001_0010; out_ready = 1'b0;
    to = 1'b1;
    for (int c = 0; c < 10 && to; c++) begin
      @(negedge clk);
      #1;
      if (out_valid) to = 1'b0;
    end
    check("midrst_reach_valid", {31'b0, to}, 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_data", out_data, 32'd0);
    syscall = 1'b0;
    #1;
    check("midrst_stall", {31'b0, stall}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(32'd11, 32'h5A, 0, st, xf, er, d0, dl, kd, unst, ev, to);
    check("post_rst_xfer", d0, 32'h5A);
    check("post_rst_stalls", st, 32'd2);
    @(negedge clk);

    // Exit: halt is sticky, later syscalls are ignored, reset clears it.
    syscall = 1'b1; v0 = 32'd10; a0 = '0;
    @(negedge clk);
    #1;
    check("exit_halt", {31'b0, halt}, 32'd1);
    check("exit_stall", {31'b0, stall}, 32'd1);
    syscall = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("halted_stall", {31'b0, stall}, 32'd1);
    check("halted_halt", {31'b0, halt}, 32'd1);
    syscall = 1'b1; v0 = 32'd11; a0 = 32'h55; out_ready = 1'b1;
    vcount = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      if (out_valid) vcount++;
    end
    check("halted_no_output", vcount, 32'd0);
    syscall = 1'b0; out_ready = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("halt_rst_halt", {31'b0, halt}, 32'd0);
    check("halt_rst_stall", {31'b0, stall}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
